gpio_button_in: RTL and testbench

GPIO_BUTTON_IN -- requirements
Module: gpio_button_in

---
 rtl/gpio_button_in_if.sv | 28 ++
 rtl/gpio_button_in.sv | 101 ++++++++++
 tb/tb_gpio_button_in.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/gpio_button_in_if.sv
// Register bus between the CPU and the button peripheral: one-cycle strobe accesses,
// registered read data and a level interrupt back to the CPU.
interface gpio_button_in_if;
  logic        sel;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (
    output sel,
    output we,
    output addr,
    output wdata,
    input  rdata,
    input  irq
  );

  modport slave (
    input  sel,
    input  we,
    input  addr,
    input  wdata,
    output rdata,
    output irq
  );
endinterface

// File: rtl/gpio_button_in.sv
// Eight-button input peripheral: per-bit synchronizer and debouncer, sticky rising-edge
// flags with write-1-to-clear, maskable level interrupt and a four-word register map.
module gpio_button_in #(
  parameter int unsigned DEBOUNCE_CYCLES = 8,
  parameter int unsigned CNT_WIDTH       = 8
) (
  input  logic               g_clk,
  input  logic               g_reset,
  input  logic [7:0]         g_buttons,
  gpio_button_in_if.slave    bus
);

  localparam logic [CNT_WIDTH-1:0] CntMax = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0] AddrState = 2'd0;
  localparam logic [1:0] AddrEdge  = 2'd1;
  localparam logic [1:0] AddrIrqEn = 2'd2;
  localparam logic [1:0] AddrRaw   = 2'd3;

  logic [7:0]           sync1_q, sync1_d;
  logic [7:0]           sync2_q, sync2_d;
  logic [CNT_WIDTH-1:0] cnt_q [8];
  logic [CNT_WIDTH-1:0] cnt_d [8];
  logic [7:0]           stable_q, stable_d;
  logic [7:0]           edge_q, edge_d;
  logic [7:0]           irq_en_q, irq_en_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 irq_q, irq_d;
  logic [7:0]           rise;

  always_comb begin
    sync1_d  = g_buttons;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    rise     = '0;
    for (int i = 0; i < 8; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          stable_d[i] = sync2_q[i];
          rise[i]     = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  always_comb begin
    edge_d   = edge_q;
    irq_en_d = irq_en_q;
    rdata_d  = rdata_q;
    if (bus.sel && bus.we) begin
      case (bus.addr)
        AddrEdge:  edge_d   = edge_q & ~bus.wdata[7:0];
        AddrIrqEn: irq_en_d = bus.wdata[7:0];
        default:   ;
      endcase
    end
    // A newly captured rising edge overrides a clear issued in the same cycle.
    edge_d = edge_d | rise;
    if (bus.sel && !bus.we) begin
      unique case (bus.addr)
        AddrState: rdata_d = {24'd0, stable_q};
        AddrEdge:  rdata_d = {24'd0, edge_q};
        AddrIrqEn: rdata_d = {24'd0, irq_en_q};
        AddrRaw:   rdata_d = {24'd0, sync2_q};
      endcase
    end
    irq_d = |(edge_q & irq_en_q);
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      edge_q   <= '0;
      irq_en_q <= '0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      edge_q   <= edge_d;
      irq_en_q <= irq_en_d;
      rdata_q  <= rdata_d;
      irq_q    <= irq_d;
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.irq   = irq_q;

endmodule

// File: tb/tb_gpio_button_in.sv
// Self-checking bench for gpio_button_in with DEBOUNCE_CYCLES=8: register-map vector table
// plus hand sequences for debounce latency, bounce, W1C collision, interrupt and reset.
module tb_gpio_button_in;

  logic       g_clk;
  logic       g_reset;
  logic [7:0] g_buttons;

  gpio_button_in_if bus ();

  gpio_button_in #(
    .DEBOUNCE_CYCLES(8),
    .CNT_WIDTH      (8)
  ) dut (
    .g_clk    (g_clk),
    .g_reset  (g_reset),
    .g_buttons(g_buttons),
    .bus      (bus.slave)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [31:0] exp_q [$];
  string       name_q [$];
  vec_t        vecs [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Issues one access; rdata after that edge is compared against the pushed expectation.
  task automatic access(input logic w, input logic [1:0] a, input logic [31:0] d,
                        input logic [31:0] exp, input string nm);
    bus.sel   = 1'b1;
    bus.we    = w;
    bus.addr  = a;
    bus.wdata = d;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    @(negedge g_clk);
    bus.sel = 1'b0;
    bus.we  = 1'b0;
    chk(name_q.pop_front(), bus.rdata, exp_q.pop_front());
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string nm);
    access(1'b0, a, 32'd0, exp, nm);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.sel   = 1'b1;
    bus.we    = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    @(negedge g_clk);
    bus.sel = 1'b0;
    bus.we  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge g_clk);
  endtask

  initial begin
    vecs[0] = '{1'b1, 2'd0, 32'h0000_00FF, 32'h6D};
    vecs[1] = '{1'b0, 2'd0, 32'h0,         32'h6D};
    vecs[2] = '{1'b1, 2'd3, 32'h0000_0000, 32'h6D};
    vecs[3] = '{1'b0, 2'd3, 32'h0,         32'h6D};
    vecs[4] = '{1'b1, 2'd2, 32'hFFFF_FFA5, 32'h6D};
    vecs[5] = '{1'b0, 2'd2, 32'h0,         32'hA5};
    vecs[6] = '{1'b0, 2'd1, 32'h0,         32'h6D};
    vecs[7] = '{1'b1, 2'd1, 32'h0000_0000, 32'h6D};
    vecs[8] = '{1'b0, 2'd1, 32'h0,         32'h6D};
    vecs[9] = '{1'b0, 2'd0, 32'h0,         32'h6D};

    g_reset   = 1'b1;
    g_buttons = 8'h00;
    bus.sel   = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = 2'd0;
    bus.wdata = 32'd0;
    idle(3);
    g_reset = 1'b0;
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_irq", {31'd0, bus.irq}, 32'd0);
    for (int a = 0; a < 4; a++) rd(2'(a), 32'd0, "rst_regs");

    // Clean press: button set up before edge 1, stable after edge 10.
    g_buttons = 8'h01;
    for (int j = 1; j <= 12; j++) rd(2'd0, (j >= 11) ? 32'h1 : 32'h0, "press_state");
    rd(2'd1, 32'h1, "press_edge");
    rd(2'd0, 32'h1, "press_state_hold");

    // Bounce on bit 3 every 3 cycles for 30 cycles, then hold high.
    for (int t = 0; t < 30; t++) begin
      if (t % 3 == 0) g_buttons[3] = ~g_buttons[3];
      rd(2'd0, 32'h01, "bounce_state");
    end
    g_buttons[3] = 1'b1;
    for (int j = 1; j <= 12; j++) rd(2'd0, (j >= 11) ? 32'h09 : 32'h01, "bounce_settle");
    rd(2'd1, 32'h09, "bounce_edge");

    // W1C and set/clear collision.
    wr(2'd1, 32'h08);
    g_buttons = 8'h0D;
    idle(12);
    rd(2'd1, 32'h05, "edge_05");
    wr(2'd1, 32'h01);
    rd(2'd1, 32'h04, "w1c_bit0");
    g_buttons = 8'h4D;
    idle(9);
    wr(2'd1, 32'h40);
    rd(2'd1, 32'h44, "collision_set_wins");
    wr(2'd1, 32'h40);
    rd(2'd1, 32'h04, "w1c_bit6");
    chk("irq_masked_off", {31'd0, bus.irq}, 32'd0);

    // Interrupt on bit 2 only.
    wr(2'd1, 32'hFF);
    wr(2'd2, 32'h04);
    g_buttons = 8'h49;
    idle(12);
    chk("irq_release", {31'd0, bus.irq}, 32'd0);
    rd(2'd1, 32'h00, "release_no_edge");
    g_buttons = 8'h4D;
    for (int j = 1; j <= 12; j++) begin
      @(negedge g_clk);
      chk("irq_rise", {31'd0, bus.irq}, (j >= 11) ? 32'd1 : 32'd0);
    end
    wr(2'd1, 32'h04);
    chk("irq_clear_lag", {31'd0, bus.irq}, 32'd1);
    idle(1);
    chk("irq_cleared", {31'd0, bus.irq}, 32'd0);
    g_buttons = 8'h4C;
    idle(12);
    g_buttons = 8'h4D;
    for (int j = 0; j < 14; j++) begin
      @(negedge g_clk);
      chk("irq_unmasked_bit0", {31'd0, bus.irq}, 32'd0);
    end
    rd(2'd1, 32'h01, "bit0_edge_masked");

    // Reset mid-debounce of button 5 while everything stays pressed.
    g_buttons = 8'h6D;
    idle(5);
    g_reset = 1'b1;
    idle(1);
    g_reset = 1'b0;
    chk("midrst_rdata", bus.rdata, 32'd0);
    chk("midrst_irq", {31'd0, bus.irq}, 32'd0);
    rd(2'd3, 32'd0, "midrst_raw");
    rd(2'd0, 32'd0, "midrst_state");
    rd(2'd1, 32'd0, "midrst_edge");
    rd(2'd2, 32'd0, "midrst_irqen");
    for (int j = 5; j <= 12; j++) begin
      if (j % 2 == 1) rd(2'd1, (j >= 11) ? 32'h6D : 32'h0, "postrst_edge");
      else            rd(2'd0, (j >= 11) ? 32'h6D : 32'h0, "postrst_state");
    end

    // Register map vectors; write rows expect rdata to hold the previous read.
    foreach (vecs[k]) begin
      access(vecs[k].we, vecs[k].addr, vecs[k].wdata, vecs[k].exp_rdata, "regmap");
    end
    chk("irq_en_a5", {31'd0, bus.irq}, 32'd1);

    // RAW follows buttons with two-cycle latency.
    g_buttons = 8'h12;
    for (int j = 1; j <= 4; j++) rd(2'd3, (j >= 3) ? 32'h12 : 32'h6D, "raw_latency");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
